// File: rtl/player_physics.sv
// Player motion engine: position integration, gravity with terminal velocity, tile-grid
// collision snapping and a GROUND/RISE/FALL jump FSM. Optional coyote time: PLAYER_COYOTE_EN.
module player_physics #(
    parameter int POS_W        = 10,
    parameter int SPD_W        = 5,
    parameter int START_X      = 176,
    parameter int START_Y      = 99,
    parameter int X_SPEED      = 4,
    parameter int GRAVITY      = 1,
    parameter int JUMP_V       = 17,
    parameter int MAX_FALL     = 12,
    parameter int TILE_LOG2    = 5,
    parameter int ORIGIN_X     = 144,
    parameter int ORIGIN_Y     = 35,
    parameter int JUMP_BUF     = 4,
    parameter int COYOTE_TICKS = 3
) (
    input  logic                           sim_clk,
    input  logic                           reset_n,
    input  logic                           tick,
    input  logic                           jump_r,
    input  logic [3:0]                     col,
    output logic [2*POS_W+2*SPD_W+1:0]     player_state,
    output logic [1:0]                     phase
);

    typedef enum logic [1:0] {
        PH_GROUND = 2'd0,
        PH_RISE   = 2'd1,
        PH_FALL   = 2'd2
    } phase_t;

    localparam int PW1  = POS_W + 1;
    localparam int SW1  = SPD_W + 1;
    localparam int JB_W = (JUMP_BUF > 0) ? $clog2(JUMP_BUF + 1) : 1;

    localparam logic [POS_W:0]   C_TILE     = PW1'(2 ** TILE_LOG2);
    localparam logic [POS_W:0]   C_MASK     = PW1'((2 ** TILE_LOG2) - 1);
    localparam logic [POS_W:0]   C_ORG_X    = PW1'(ORIGIN_X);
    localparam logic [POS_W:0]   C_ORG_Y    = PW1'(ORIGIN_Y);
    localparam logic [POS_W-1:0] C_START_X  = POS_W'(START_X);
    localparam logic [POS_W-1:0] C_START_Y  = POS_W'(START_Y);
    localparam logic [SPD_W-1:0] C_X_SPEED  = SPD_W'(X_SPEED);
    localparam logic [SPD_W-1:0] C_GRAV     = SPD_W'(GRAVITY);
    localparam logic [SPD_W-1:0] C_JUMP_V   = SPD_W'(JUMP_V);
    localparam logic [SPD_W-1:0] C_MAX_FALL = SPD_W'(MAX_FALL);
    localparam logic [SW1-1:0]   C_MAX_W    = SW1'(MAX_FALL);
    localparam logic [JB_W-1:0]  C_JBUF     = JB_W'(JUMP_BUF);

    // Elaboration-time guard: a terminal velocity that does not fit the speed field would wrap.
    if (MAX_FALL >= (2 ** SPD_W) || COYOTE_TICKS < 0) begin : g_param_check
        $error("player_physics: MAX_FALL must be below 2**SPD_W and COYOTE_TICKS non-negative");
    end

    logic [POS_W-1:0] r_x, r_y;
    logic [SPD_W-1:0] r_xspd, r_yspd;
    logic             r_xdir, r_ydir;
    phase_t           r_phase;
    logic [JB_W-1:0]  r_jbuf;

    logic             w_armed;
    logic             w_jump;
    logic             w_coyote_jump;
    logic [POS_W:0]   w_x_sum, w_y_sum;
    logic [SW1-1:0]   w_fall_sum;
    logic [POS_W-1:0] w_nxt_x, w_nxt_y;
    logic [SPD_W-1:0] w_nxt_yspd;
    logic             w_nxt_xdir, w_nxt_ydir;
    phase_t           w_nxt_phase;

    // A load on the same cycle as a tick already counts as armed for that tick.
    assign w_armed = jump_r | (r_jbuf != '0);

    assign w_x_sum = r_xdir ? (PW1'(r_x) + PW1'(r_xspd)) : (PW1'(r_x) - PW1'(r_xspd));
    assign w_y_sum = r_ydir ? (PW1'(r_y) - PW1'(r_yspd)) : (PW1'(r_y) + PW1'(r_yspd));
    assign w_fall_sum = SW1'(r_yspd) + SW1'(C_GRAV);

`ifdef PLAYER_COYOTE_EN
    localparam int              CY_W     = (COYOTE_TICKS > 0) ? $clog2(COYOTE_TICKS + 1) : 1;
    localparam logic [CY_W-1:0] C_COYOTE = CY_W'(COYOTE_TICKS);

    logic [CY_W-1:0] r_coyote;
    logic [CY_W-1:0] w_nxt_coyote;

    assign w_coyote_jump = (r_phase == PH_FALL) && (r_coyote != '0) && w_armed;

    // Loaded only on a walk-off; every other path (landing, jumping, rising) clears it.
    always_comb begin
        w_nxt_coyote = '0;
        if (r_phase == PH_GROUND && !w_armed && !col[1]) begin
            w_nxt_coyote = C_COYOTE;
        end else if (r_phase == PH_FALL && !w_coyote_jump && !col[1] && r_coyote != '0) begin
            w_nxt_coyote = r_coyote - CY_W'(1);
        end
    end

    always_ff @(posedge sim_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coyote <= '0;
        end else if (tick) begin
            r_coyote <= w_nxt_coyote;
        end
    end
`else
    assign w_coyote_jump = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_nxt_x     = POS_W'(w_x_sum);
        w_nxt_xdir  = r_xdir;
        w_nxt_y     = POS_W'(w_y_sum);
        w_nxt_yspd  = r_yspd;
        w_nxt_ydir  = r_ydir;
        w_nxt_phase = r_phase;
        w_jump      = 1'b0;

        if (col[0] | col[2]) begin
            w_nxt_xdir = ~r_xdir;
            if (r_xdir) begin
                w_nxt_x = POS_W'(w_x_sum - ((w_x_sum - C_ORG_X) & C_MASK) - PW1'(1));
            end else begin
                w_nxt_x = POS_W'(w_x_sum + (C_TILE - ((w_x_sum - C_ORG_X) & C_MASK)));
            end
        end

        case (r_phase)
            PH_GROUND: begin
                if (w_armed) begin
                    w_jump = 1'b1;
                end else if (!col[1]) begin
                    w_nxt_phase = PH_FALL;
                    w_nxt_yspd  = '0;
                end else begin
                    w_nxt_yspd  = '0;
                end
            end
            PH_RISE: begin
                if (col[3]) begin
                    w_nxt_y     = POS_W'(w_y_sum + (C_TILE - ((w_y_sum - C_ORG_Y) & C_MASK)));
                    w_nxt_yspd  = '0;
                    w_nxt_ydir  = 1'b0;
                    w_nxt_phase = PH_FALL;
                end else if (r_yspd > C_GRAV) begin
                    w_nxt_yspd  = r_yspd - C_GRAV;
                end else begin
                    w_nxt_yspd  = '0;
                    w_nxt_ydir  = 1'b0;
                    w_nxt_phase = PH_FALL;
                end
            end
            PH_FALL: begin
                if (w_coyote_jump) begin
                    w_jump = 1'b1;
                end else if (col[1]) begin
                    w_nxt_y     = POS_W'(w_y_sum - ((w_y_sum - C_ORG_Y) & C_MASK) - PW1'(1));
                    w_nxt_yspd  = '0;
                    w_nxt_phase = PH_GROUND;
                end else if (w_fall_sum > C_MAX_W) begin
                    w_nxt_yspd  = C_MAX_FALL;
                end else begin
                    w_nxt_yspd  = SPD_W'(w_fall_sum);
                end
            end
            default: begin
                w_nxt_phase = PH_FALL;
            end
        endcase

        if (w_jump) begin
            w_nxt_yspd  = C_JUMP_V;
            w_nxt_ydir  = 1'b1;
            w_nxt_phase = PH_RISE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sim_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= C_START_X;
            r_y     <= C_START_Y;
            r_xspd  <= C_X_SPEED;
            r_yspd  <= '0;
            r_xdir  <= 1'b1;
            r_ydir  <= 1'b0;
            r_phase <= PH_FALL;
            r_jbuf  <= '0;
        end else begin
            // A fresh request outranks both the per-tick decrement and the clear on a jump.
            if (jump_r) begin
                r_jbuf <= C_JBUF;
            end else if (tick) begin
                if (w_jump || r_jbuf == '0) begin
                    r_jbuf <= '0;
                end else begin
                    r_jbuf <= r_jbuf - JB_W'(1);
                end
            end

            if (tick) begin
                r_x     <= w_nxt_x;
                r_y     <= w_nxt_y;
                r_xspd  <= C_X_SPEED;
                r_yspd  <= w_nxt_yspd;
                r_xdir  <= w_nxt_xdir;
                r_ydir  <= w_nxt_ydir;
                r_phase <= w_nxt_phase;
            end
        end
    end

    assign player_state = {r_x, r_y, r_xspd, r_yspd, r_xdir, r_ydir};
    assign phase        = r_phase;

endmodule

// File: tb/tb_player_physics.sv
// Self-checking bench for player_physics: hand-computed vector table, corner sequences and
// randomized stimulus against an integer reference model. Honours PLAYER_COYOTE_EN.
module tb_player_physics;

    localparam int POS_W    = 10;
    localparam int SPD_W    = 5;
    localparam int M        = 1 << POS_W;
    localparam int T        = 32;
    localparam int START_X  = 176;
    localparam int START_Y  = 99;
    localparam int XS       = 4;
    localparam int GRAV     = 1;
    localparam int JV       = 17;
    localparam int MAXF     = 12;
    localparam int OX       = 144;
    localparam int OY       = 35;
    localparam int JBUF     = 4;
    localparam int COYOTE   = 3;
    localparam int P_GROUND = 0;
    localparam int P_RISE   = 1;
    localparam int P_FALL   = 2;

    logic                      sim_clk;
    logic                      reset_n;
    logic                      tick;
    logic                      jump_r;
    logic [3:0]                col;
    logic [2*POS_W+2*SPD_W+1:0] player_state;
    logic [1:0]                phase;

    int total = 0;
    int bad   = 0;

    player_physics dut (
        .sim_clk      (sim_clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .jump_r       (jump_r),
        .col          (col),
        .player_state (player_state),
        .phase        (phase)
    );

    initial sim_clk = 1'b0;
    always #5 sim_clk = ~sim_clk;

    wire [POS_W-1:0] o_x    = player_state[31:22];
    wire [POS_W-1:0] o_y    = player_state[21:12];
    wire [SPD_W-1:0] o_xspd = player_state[11:7];
    wire [SPD_W-1:0] o_yspd = player_state[6:2];
    wire             o_xdir = player_state[1];
    wire             o_ydir = player_state[0];

    // Reference model state, plain integers.
    int m_x, m_y, m_yspd, m_xdir, m_ydir, m_phase, m_buf, m_coy;

    function automatic int wrap(input int v);
        return ((v % M) + M) % M;
    endfunction

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_yspd = 0; m_xdir = 1; m_ydir = 0;
        m_phase = P_FALL; m_buf = 0; m_coy = 0;
    endtask

    task automatic model_step(input logic t, input logic j, input logic [3:0] c);
        bit armed, jumped;
        int nx, ny;
        armed  = j || (m_buf != 0);
        jumped = 0;
        if (t) begin
            nx = m_xdir ? m_x + XS : m_x - XS;
            if (c[0] || c[2]) begin
                if (m_xdir) nx = nx - (wrap(nx - OX) & (T - 1)) - 1;
                else        nx = nx + T - (wrap(nx - OX) & (T - 1));
                m_xdir = 1 - m_xdir;
            end
            ny = m_ydir ? m_y - m_yspd : m_y + m_yspd;
            if (m_phase == P_GROUND) begin
                if (armed) jumped = 1;
                else if (!c[1]) begin
                    m_phase = P_FALL; m_yspd = 0;
`ifdef PLAYER_COYOTE_EN
                    m_coy = COYOTE;
`endif
                end else m_yspd = 0;
            end else if (m_phase == P_RISE) begin
                m_coy = 0;
                if (c[3]) begin
                    ny = ny + T - (wrap(ny - OY) & (T - 1));
                    m_yspd = 0; m_ydir = 0; m_phase = P_FALL;
                end else if (m_yspd > GRAV) m_yspd = m_yspd - GRAV;
                else begin
                    m_yspd = 0; m_ydir = 0; m_phase = P_FALL;
                end
            end else begin
                if (m_coy != 0 && armed) jumped = 1;
                else if (c[1]) begin
                    ny = ny - (wrap(ny - OY) & (T - 1)) - 1;
                    m_yspd = 0; m_phase = P_GROUND; m_coy = 0;
                end else begin
                    m_yspd = (m_yspd + GRAV > MAXF) ? MAXF : m_yspd + GRAV;
                    if (m_coy > 0) m_coy = m_coy - 1;
                end
            end
            if (jumped) begin
                m_yspd = JV; m_ydir = 1; m_phase = P_RISE; m_coy = 0;
            end
            m_x = wrap(nx);
            m_y = wrap(ny);
        end
        if (j) m_buf = JBUF;
        else if (t) m_buf = (jumped || m_buf == 0) ? 0 : m_buf - 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, land on the next negedge.
    task automatic step(input logic t, input logic j, input logic [3:0] c);
        tick = t; jump_r = j; col = c;
        model_step(t, j, c);
        @(negedge sim_clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " x"},     int'(o_x), START_X);
        check({tag, " y"},     int'(o_y), START_Y);
        check({tag, " xspd"},  int'(o_xspd), XS);
        check({tag, " yspd"},  int'(o_yspd), 0);
        check({tag, " xdir"},  int'(o_xdir), 1);
        check({tag, " ydir"},  int'(o_ydir), 0);
        check({tag, " phase"}, int'(phase), P_FALL);
    endtask

    task automatic do_reset();
        tick = 1'b0; jump_r = 1'b0; col = 4'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge sim_clk);
        check_reset_values("reset");
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       t;
        logic       j;
        logic [3:0] c;
        int         ex, ey, eys, eydir, eph;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] exp_state;
        int          prev_y;

        // Free fall, buffered jump through a landing, top snap, walk-off.
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 180,  99,  1, 0, P_FALL};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 184, 100,  2, 0, P_FALL};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000, 188, 102,  3, 0, P_FALL};
        vecs[3]  = '{1'b1, 1'b0, 4'b0000, 192, 105,  4, 0, P_FALL};
        vecs[4]  = '{1'b1, 1'b0, 4'b0000, 196, 109,  5, 0, P_FALL};
        vecs[5]  = '{1'b0, 1'b1, 4'b0000, 196, 109,  5, 0, P_FALL};
        vecs[6]  = '{1'b1, 1'b0, 4'b0000, 200, 114,  6, 0, P_FALL};
        vecs[7]  = '{1'b1, 1'b0, 4'b0010, 204,  98,  0, 0, P_GROUND};
        vecs[8]  = '{1'b1, 1'b0, 4'b0010, 208,  98, 17, 1, P_RISE};
        vecs[9]  = '{1'b1, 1'b0, 4'b0000, 212,  81, 16, 1, P_RISE};
        vecs[10] = '{1'b1, 1'b0, 4'b1000, 216,  67,  0, 0, P_FALL};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 220,  67,  1, 0, P_FALL};
        vecs[12] = '{1'b0, 1'b0, 4'b0010, 220,  67,  1, 0, P_FALL};
        vecs[13] = '{1'b1, 1'b0, 4'b0010, 224,  66,  0, 0, P_GROUND};
        vecs[14] = '{1'b1, 1'b0, 4'b0010, 228,  66,  0, 0, P_GROUND};
        vecs[15] = '{1'b1, 1'b0, 4'b0000, 232,  66,  0, 0, P_FALL};
        vecs[16] = '{1'b1, 1'b0, 4'b0000, 236,  66,  1, 0, P_FALL};

        reset_n = 1'b0; tick = 1'b0; jump_r = 1'b0; col = 4'b0;
        @(negedge sim_clk);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].t, vecs[i].j, vecs[i].c);
            check($sformatf("vec%0d x", i),     int'(o_x),    vecs[i].ex);
            check($sformatf("vec%0d y", i),     int'(o_y),    vecs[i].ey);
            check($sformatf("vec%0d yspd", i),  int'(o_yspd), vecs[i].eys);
            check($sformatf("vec%0d ydir", i),  int'(o_ydir), vecs[i].eydir);
            check($sformatf("vec%0d phase", i), int'(phase),  vecs[i].eph);
        end

        // Coyote: jump requested two ticks after walking off.
        step(1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        check("coyote y", int'(o_y), 67);
`ifdef PLAYER_COYOTE_EN
        check("coyote yspd",  int'(o_yspd), JV);
        check("coyote phase", int'(phase),  P_RISE);
`else
        check("coyote yspd",  int'(o_yspd), 2);
        check("coyote phase", int'(phase),  P_FALL);
`endif

        // Terminal velocity.
        do_reset();
        prev_y = START_Y;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 4'b0000);
            check($sformatf("term yspd t%0d", i), int'(o_yspd), (i > MAXF) ? MAXF : i);
            check($sformatf("term dy t%0d", i), wrap(int'(o_y) - prev_y),
                  (i - 1 > MAXF) ? MAXF : i - 1);
            prev_y = int'(o_y);
        end

        // Right wall then left wall.
        do_reset();
        repeat (6) step(1'b1, 1'b0, 4'b0000);
        check("wall pre x", int'(o_x), 200);
        step(1'b1, 1'b0, 4'b0100);
        check("right wall x",    int'(o_x),    175);
        check("right wall xdir", int'(o_xdir), 0);
        step(1'b1, 1'b0, 4'b0001);
        check("left wall x",    int'(o_x),    176);
        check("left wall xdir", int'(o_xdir), 1);

        // A request five ticks before landing has expired by the first GROUND tick.
        do_reset();
        step(1'b0, 1'b1, 4'b0000);
        repeat (4) step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0010);
        check("stale land y",     int'(o_y),   98);
        check("stale land phase", int'(phase), P_GROUND);
        step(1'b1, 1'b0, 4'b0010);
        check("stale phase", int'(phase),  P_GROUND);
        check("stale yspd",  int'(o_yspd), 0);

        // Load and tick on the same edge jump immediately; then reset mid-RISE.
        do_reset();
        step(1'b1, 1'b0, 4'b0010);
        check("pre-jump y",     int'(o_y),   98);
        check("pre-jump phase", int'(phase), P_GROUND);
        step(1'b1, 1'b1, 4'b0010);
        check("same-edge yspd",  int'(o_yspd), JV);
        check("same-edge ydir",  int'(o_ydir), 1);
        check("same-edge phase", int'(phase),  P_RISE);
        #2;
        reset_n = 1'b0; tick = 1'b0; jump_r = 1'b0; col = 4'b0;
        #1;
        check_reset_values("async reset");
        model_reset();
        @(negedge sim_clk);
        reset_n = 1'b1;

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       rt, rj;
            logic [3:0] rc;
            rt = ($urandom_range(0, 3) != 0);
            rj = ($urandom_range(0, 11) == 0);
            for (int b = 0; b < 4; b++) rc[b] = ($urandom_range(0, 5) == 0);
            step(rt, rj, rc);
            exp_state = {POS_W'(m_x), POS_W'(m_y), SPD_W'(XS), SPD_W'(m_yspd),
                         1'(m_xdir), 1'(m_ydir)};
            check($sformatf("rand%0d state", i), int'(player_state), int'(exp_state));
            check($sformatf("rand%0d phase", i), int'(phase), m_phase);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_physics.md
# player_physics

Parametrised player motion engine for the playfield. It is the next generation of the fixed-constant player block. It integrates position from per-axis speed and direction, and applies gravity with a terminal-velocity clamp. It resolves wall, floor and ceiling collisions by snapping to the tile grid, and runs an explicit GROUND/RISE/FALL state machine with jump buffering. It sits between the collision detector (which drives `col`) and the renderer (which consumes `player_state`).

## Interface
- `POS_W`, 10: x/y position width; arithmetic wraps modulo 2^POS_W.
- `SPD_W`, 5: x/y speed width.
- `START_X`, 176: x position after reset.
- `START_Y`, 99: y position after reset.
- `X_SPEED`, 4: constant horizontal speed.
- `GRAVITY`, 1: y-speed change per tick.
- `JUMP_V`, 17: initial upward speed on a jump.
- `MAX_FALL`, 12: terminal downward speed; must be < 2^SPD_W.
- `TILE_LOG2`, 5: tile size is 2^TILE_LOG2 pixels.
- `ORIGIN_X`, 144: playfield pixel origin, x.
- `ORIGIN_Y`, 35: playfield pixel origin, y.
- `JUMP_BUF`, 4: ticks a jump request stays armed.
- `COYOTE_TICKS`, 3: grace ticks after leaving ground (only with macro).
- `sim_clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: physics step enable; all state except the jump-buffer load advances only when high.
- `jump_r` in 1: jump request, sampled every `sim_clk` cycle.
- `col` in 4: collision flags; bit0 left, bit1 bottom, bit2 right, bit3 top.
- `player_state` out 2*POS_W+2*SPD_W+2: packed {x, y, xspd, yspd, xdir, ydir}; xdir 1=right, ydir 1=up.
- `phase` out 2: 0 GROUND, 1 RISE, 2 FALL.

## Operation
- Reset values: x=START_X, y=START_Y, xspd=X_SPEED, yspd=0, xdir=right, ydir=down, phase=FALL, jump buffer=0, coyote counter=0.
- Jump buffer load: `jump_r`=1 on any cycle loads the buffer with JUMP_BUF. The load is independent of `tick`.
- Jump buffer decrement: on each tick with no load, the buffer decrements and saturates at 0. "Armed" means buffer≠0.
- Per tick, position integrates from the *old* speed:
  - x ± xspd, per xdir.
  - y + yspd when down, y − yspd when up.
- GROUND:
  - If armed: yspd=JUMP_V, ydir=up, phase→RISE, buffer cleared. The jump beats the bottom-collision snap.
  - Else if `col[1]`=0: phase→FALL, yspd=0.
  - Else: yspd held at 0.
- RISE:
  - If yspd>GRAVITY: yspd−=GRAVITY.
  - Else: yspd=0, ydir=down, phase→FALL.
- FALL: yspd=min(yspd+GRAVITY, MAX_FALL).
- Horizontal collision (`col[0]|col[2]`) snaps x and flips xdir. This is independent of the vertical logic.
  - Moving left: x ← x−xspd + (T − ((x−xspd−ORIGIN_X) & (T−1))).
  - Moving right: x ← x+xspd − ((x+xspd−ORIGIN_X) & (T−1)) − 1.
- Bottom collision (`col[1]`) in FALL:
  - y ← y+yspd − ((y+yspd−ORIGIN_Y) & (T−1)) − 1.
  - yspd=0, phase→GROUND.
- Top collision (`col[3]`) in RISE:
  - y ← y−yspd + (T − ((y−yspd−ORIGIN_Y) & (T−1))).
  - yspd=0, ydir=down, phase→FALL.
- Priority:
  - Collision snaps override integration and gravity on the same axis.
  - `col[1]` is ignored in RISE; `col[3]` is ignored in FALL and GROUND.
- Widths: intermediate sums are computed at POS_W+1 and truncated to POS_W. Speeds never exceed their clamps, so no speed overflow occurs.

## Timing
- All outputs are registered and update on the `sim_clk` edge where `tick`=1. There is one tick of latency from `col`/armed to `player_state`.
- With `tick`=0, all outputs and phase hold. Only the jump-buffer load can occur.
- `reset_n` low forces reset values immediately, including mid-jump and mid-snap. The first update after deassertion occurs on the first tick edge.
- Simultaneous jump_r load and tick:
  - The load wins; the buffer becomes JUMP_BUF.
  - The tick still sees the armed state, so a GROUND player jumps on that same edge.

## Configuration
- `PLAYER_COYOTE_EN` defined:
  - On GROUND→FALL by walking off (not by jumping), the coyote counter loads COYOTE_TICKS.
  - The counter decrements each tick while in FALL.
  - While the counter≠0, an armed FALL tick performs a GROUND-style jump and clears the counter.
  - Landing or entering RISE clears the counter.
- Undefined: no counter logic is built, and jumps fire only from GROUND.

## Test plan
- Free fall: release reset, `col`=0, 3 ticks. Required: x 180/184/188; y 99/100/102; final yspd=3; phase=FALL.
- Terminal velocity: free fall for 20 ticks. Required: yspd saturates at 12 and never exceeds it; y advances by 12 per tick after saturation.
- Landing: FALL, y=190, yspd=8, `col`=4'b0010, one tick. Required: y=194, yspd=0, phase=GROUND.
- Buffered jump: pulse `jump_r` 2 ticks before the landing tick. Required: landing tick gives GROUND; next tick gives yspd=17, ydir=up, phase=RISE. The same pulse 5 ticks before landing gives no jump.
- Right wall: x=200, xdir=right, `col`=4'b0100. Required: x=175, xdir=left. Also assert `reset_n` low mid-RISE. Required: all outputs return to their reset values without a clock edge.
- Coyote: GROUND, drop `col[1]`, pulse `jump_r` 2 ticks later. Required with `PLAYER_COYOTE_EN`: yspd=17, phase=RISE. Required without it: phase stays FALL.
